// File: rtl/fsm_key_pkg.sv
// Shared types and constants for the key-entry sequencer: key ROM, state encoding,
// and the mask LFSR step function.
package fsm_key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_e;

    // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Entries beyond KEY_LEN-1 are never reached with the default length
    localparam logic [7:0] KEY [8] = '{
        8'h3C, 8'hA7, 8'h5E, 8'h91,
        8'h4B, 8'hD2, 8'h6F, 8'h18
    };

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8_mask.sv
// 8-bit Fibonacci mask generator; holds its value while en is low and reloads SEED on reset.
module lfsr8_mask
    import fsm_key_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (en) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign q = r_lfsr;

endmodule

// File: rtl/fsm_key_sequencer.sv
// Key-sequence gate in front of a protected FSM: scrambles x_in with an LFSR mask until the
// ordered key sequence is entered, and latches a permanent lockout after too many mismatches.
module fsm_key_sequencer
    import fsm_key_pkg::*;
#(
    parameter int unsigned KEY_LEN   = 4,
    parameter int unsigned KEY_W     = 8,
    parameter int unsigned MAX_FAIL  = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    input  logic             relock,
    input  logic [7:0]       x_in,
    output logic [7:0]       x_out,
    output logic             unlocked,
    output logic             lockout,
    output logic [2:0]       key_idx,
    output logic [2:0]       fail_cnt
);

    localparam logic [2:0] LastIdx  = 3'(KEY_LEN - 1);
    localparam logic [2:0] FailMax  = 3'(MAX_FAIL);

    state_e             r_state;
    logic [2:0]         r_key_idx;
    logic [2:0]         r_fail_cnt;
    logic               r_unlocked;
    logic               r_lockout;

    logic [KEY_W-1:0]   w_key_word;
    logic               w_match;
    logic [2:0]         w_fail_next;
    logic [7:0]         w_lfsr;
    logic               w_lfsr_en;

    assign w_key_word  = KEY_W'(KEY[r_key_idx]);
    assign w_match     = (key_in == w_key_word);
    assign w_fail_next = (r_fail_cnt == FailMax) ? r_fail_cnt : r_fail_cnt + 3'd1;
    assign w_lfsr_en   = (r_state != UNLOCKED);

    lfsr8_mask #(
        .SEED (LFSR_SEED)
    ) u_mask (
        .clk (clk),
        .rst (rst),
        .en  (w_lfsr_en),
        .q   (w_lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_key_idx  <= 3'd0;
            r_fail_cnt <= 3'd0;
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, CHECK: begin
                    if (key_valid) begin
                        if (w_match) begin
                            if (r_key_idx == LastIdx) begin
                                r_state    <= UNLOCKED;
                                r_key_idx  <= 3'd0;
                                r_unlocked <= 1'b1;
                            end else begin
                                r_state   <= CHECK;
                                r_key_idx <= r_key_idx + 3'd1;
                            end
                        end else begin
                            r_key_idx  <= 3'd0;
                            r_fail_cnt <= w_fail_next;
                            if (w_fail_next == FailMax) begin
                                r_state   <= LOCKOUT;
                                r_lockout <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                // relock beats a simultaneous key word, which is simply dropped
                UNLOCKED: begin
                    if (relock) begin
                        r_state    <= IDLE;
                        r_key_idx  <= 3'd0;
                        r_unlocked <= 1'b0;
                    end
                end
                LOCKOUT: begin
                    r_state <= LOCKOUT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        x_out = x_in ^ w_lfsr;
        unique case (r_state)
            UNLOCKED: x_out = x_in;
            LOCKOUT:  x_out = ~x_in;
            default:  x_out = x_in ^ w_lfsr;
        endcase
    end

    assign unlocked = r_unlocked;
    assign lockout  = r_lockout;
    assign key_idx  = r_key_idx;
    assign fail_cnt = r_fail_cnt;

endmodule

// File: doc/fsm_key_sequencer.md
# fsm_key_sequencer

Sequential key-entry controller in front of a protected benchmark FSM such as the 8-input/17-output controllers. It watches a key bus over multiple cycles and checks for a fixed ordered key sequence. Until the full sequence is accepted, it corrupts the FSM's 8-bit primary input vector with an LFSR mask. After a set number of wrong attempts it locks out permanently; only reset clears the lockout.

## Interface
Parameters:
- KEY_LEN, 4, number of key words in the sequence (2..8)
- KEY_W, 8, width of one key word
- MAX_FAIL, 3, mismatches allowed before lockout (1..7)
- LFSR_SEED, 8'hA5, mask LFSR value after reset; must be nonzero

Ports (reset is asynchronous, active-high; all state updates on rising clk edge):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- key_valid  in  1  key_in holds a key word this cycle
- key_in  in  KEY_W  key word
- relock  in  1  single-cycle request to re-lock from UNLOCKED
- x_in  in  8  primary inputs x1..x8 (bit0 = x1)
- x_out  out  8  inputs forwarded to the protected FSM
- unlocked  out  1  high in UNLOCKED
- lockout  out  1  high in LOCKOUT
- key_idx  out  3  index of the next expected key word
- fail_cnt  out  3  mismatches since reset

## Operation
- States:
  - IDLE: no key word accepted since reset or relock.
  - CHECK: partial sequence accepted.
  - UNLOCKED: full sequence accepted.
  - LOCKOUT: too many mismatches.
- Reset values: state IDLE, key_idx 0, fail_cnt 0, lfsr LFSR_SEED, unlocked 0, lockout 0.
- IDLE/CHECK with key_valid:
  - key_in == KEY[key_idx]: key_idx increments and the state becomes CHECK.
  - If key_idx == KEY_LEN-1 on a match, the state becomes UNLOCKED and key_idx returns to 0.
  - key_in != KEY[key_idx]: key_idx returns to 0, fail_cnt increments, and the state becomes IDLE.
  - If the incremented fail_cnt == MAX_FAIL, the state becomes LOCKOUT instead.
- IDLE/CHECK without key_valid: hold. There is no timeout.
- UNLOCKED:
  - key_valid is ignored.
  - relock returns the state to IDLE with key_idx 0. fail_cnt is retained and the LFSR restarts from its current value.
- LOCKOUT: absorbing state. Ignores key_valid and relock; only rst exits.
- relock outside UNLOCKED: ignored.
- Mask LFSR:
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left with feedback into bit0.
  - Advances every cycle when the state is not UNLOCKED; frozen in UNLOCKED.
- x_out, combinational from registered state:
  - UNLOCKED: x_in.
  - LOCKOUT: ~x_in.
  - Otherwise: x_in ^ lfsr.
- fail_cnt saturates at MAX_FAIL and never wraps.

## Timing
- A key word is sampled on the rising edge where key_valid=1. State, key_idx and fail_cnt reflect it after that edge.
- unlocked rises one cycle after the last correct key word is sampled. From that same cycle x_out == x_in.
- Lockout latency: lockout rises one cycle after the MAX_FAIL-th mismatch is sampled.
- relock and key_valid in the same cycle in UNLOCKED: relock wins and the key word is dropped.
- x_out is combinational from registered state, valid well before the falling edge on which the protected FSM samples.
- rst mid-sequence: immediate return to IDLE with all counters cleared. x_out then switches to x_in ^ LFSR_SEED.

## Structure
- Package fsm_key_pkg holds:
  - Key ROM constant KEY[0..7], with KEY[0..3] = 8'h3C, 8'hA7, 8'h5E, 8'h91.
  - State enum {IDLE, CHECK, UNLOCKED, LOCKOUT}.
  - LFSR tap mask 8'hB8.
- One sub-module, lfsr8_mask, with inputs clk, rst and en, and output q. It carries the seed parameter.
- The comparator and counters live in the top-level FSM.

## Test plan
- Correct sequence: after reset, apply 3C, A7, 5E, 91 on consecutive cycles.
  - unlocked=1 on the cycle after 91.
  - x_in=8'h5A gives x_out=8'h5A.
  - fail_cnt=0.
- Partial then wrong: apply 3C, A7, then FF.
  - key_idx goes 1, 2, then 0.
  - fail_cnt=1, state IDLE, unlocked stays 0.
- Lockout: three sequences that are each wrong at word 0.
  - lockout=1 one cycle after the third mismatch.
  - A later correct sequence leaves unlocked=0.
  - x_in=8'h0F gives x_out=8'hF0.
- Relock: from UNLOCKED, pulse relock while applying key_valid with 3C.
  - State IDLE and key_idx 0.
  - x_out != x_in on the next cycle.
  - A fresh full sequence re-unlocks.
- Reset mid-sequence: assert rst asynchronously after 3C, A7.
  - key_idx=0 and fail_cnt=0 immediately.
  - First cycle after release with x_in=0: x_out=8'hA5.
- Mask check: in IDLE with x_in=0 held for 4 cycles, x_out follows the LFSR sequence starting at A5.
  - The bench checks it against a reference model, including gaps in key_valid where no state change occurs.
